// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2x2 stride-2 streaming max-pool stage.
// Holds the FSM state codes, the default lane geometry and the signed lane-pair max helper.
package maxpool_pkg;

  localparam int DEF_SYSTOLIC_SIZE = 16;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int OUT_LANES         = DEF_SYSTOLIC_SIZE / 2;

  // Wide enough for any practical DATA_WIDTH once callers sign-extend their operands.
  localparam int MAX_W = 64;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EVEN  = 2'd1;
  localparam logic [1:0] S_ODD   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  function automatic logic signed [MAX_W-1:0] lane_max(input logic signed [MAX_W-1:0] a,
                                                       input logic signed [MAX_W-1:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_line_buffer.sv
// Line buffer holding the horizontal maxima of the most recent even conv row, one entry per tile.
// Contents are intentionally not reset; every entry is rewritten before it is read.
module maxpool_line_buffer
  import maxpool_pkg::*;
#(
  parameter int DEPTH      = 26,
  parameter int LANES      = OUT_LANES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AW         = 5
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic [LANES*DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]               raddr,
  output logic [LANES*DATA_WIDTH-1:0] rdata
);

  logic [LANES*DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [LANES*DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 max-pool between the systolic array output and the OFM RAM write port.
// Define MAXPOOL_RELU_EN to clamp negative input lanes to zero ahead of pooling.
module maxpool_2x2_stream
  import maxpool_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int LINE_TILES    = 26,
  parameter int CONV_ROWS     = 416
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]     in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [(SYSTOLIC_SIZE/2)*DATA_WIDTH-1:0] out_data,
  output logic                                    out_row_last,
  output logic                                    done
);

  localparam int LANES = SYSTOLIC_SIZE / 2;
  localparam int OW    = LANES * DATA_WIDTH;
  localparam int TW    = (LINE_TILES > 1) ? $clog2(LINE_TILES) : 1;
  localparam int RW    = $clog2(CONV_ROWS + 1);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tile_cnt_q, tile_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic          out_row_last_q, out_row_last_d;
  logic          done_q, done_d;

  logic [OW-1:0] hmax, pooled, lb_rdata;
  logic          in_accept, out_drain, tile_last;
  logic [RW-1:0] row_next;

  function automatic logic signed [DATA_WIDTH-1:0] prep(input logic signed [DATA_WIDTH-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] max2(input logic signed [DATA_WIDTH-1:0] a,
                                                        input logic signed [DATA_WIDTH-1:0] b);
    return DATA_WIDTH'(lane_max(MAX_W'(a), MAX_W'(b)));
  endfunction

  always_comb begin
    hmax   = '0;
    pooled = '0;
    for (int j = 0; j < LANES; j++) begin
      hmax[j*DATA_WIDTH +: DATA_WIDTH]   = max2(prep(in_data[(2*j)*DATA_WIDTH +: DATA_WIDTH]),
                                                prep(in_data[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]));
      pooled[j*DATA_WIDTH +: DATA_WIDTH] = max2(hmax[j*DATA_WIDTH +: DATA_WIDTH],
                                                lb_rdata[j*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  maxpool_line_buffer #(
    .DEPTH     (LINE_TILES),
    .LANES     (LANES),
    .DATA_WIDTH(DATA_WIDTH),
    .AW        (TW)
  ) u_line_buffer (
    .clk  (clk),
    .we   (in_accept && (state_q == S_EVEN)),
    .waddr(tile_cnt_q),
    .wdata(hmax),
    .raddr(tile_cnt_q),
    .rdata(lb_rdata)
  );

  always_comb begin
    case (state_q)
      S_EVEN:  in_ready = 1'b1;
      S_ODD:   in_ready = !out_valid_q || out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign in_accept = in_valid && in_ready;
  assign out_drain = out_valid_q && out_ready;
  assign tile_last = (tile_cnt_q == TW'(LINE_TILES - 1));
  assign row_next  = row_cnt_q + RW'(1);

  // The final row of an odd-height plane leaves EVEN straight to FLUSH, giving floor pooling.
  always_comb begin
    state_d        = state_q;
    tile_cnt_d     = tile_cnt_q;
    row_cnt_d      = row_cnt_q;
    out_valid_d    = out_drain ? 1'b0 : out_valid_q;
    out_data_d     = out_data_q;
    out_row_last_d = out_row_last_q;
    done_d         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_EVEN;
          tile_cnt_d = '0;
          row_cnt_d  = '0;
        end
      end
      S_EVEN: begin
        if (in_accept) begin
          if (tile_last) begin
            tile_cnt_d = '0;
            row_cnt_d  = row_next;
            state_d    = (row_next == RW'(CONV_ROWS)) ? S_FLUSH : S_ODD;
          end else begin
            tile_cnt_d = tile_cnt_q + TW'(1);
          end
        end
      end
      S_ODD: begin
        if (in_accept) begin
          out_valid_d    = 1'b1;
          out_data_d     = pooled;
          out_row_last_d = tile_last;
          if (tile_last) begin
            tile_cnt_d = '0;
            row_cnt_d  = row_next;
            state_d    = (row_next == RW'(CONV_ROWS)) ? S_FLUSH : S_EVEN;
          end else begin
            tile_cnt_d = tile_cnt_q + TW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (!out_valid_q || out_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      tile_cnt_q     <= '0;
      row_cnt_q      <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_row_last_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tile_cnt_q     <= tile_cnt_d;
      row_cnt_q      <= row_cnt_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_row_last_q <= out_row_last_d;
      done_q         <= done_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_row_last = out_row_last_q;
  assign done         = done_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Directed bench for maxpool_2x2_stream on a small 4-lane, 2-tile, 3-row plane (odd height).
// Pooling windows come from a table of hand-computed raw and ReLU expectations.
module tb_maxpool_2x2_stream;

  localparam int SS = 4;
  localparam int DW = 16;
  localparam int LT = 2;
  localparam int CR = 3;
  localparam int OL = SS / 2;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, in_ready;
  logic              out_valid, out_ready, out_row_last, done;
  logic [SS*DW-1:0]  in_data;
  logic [OL*DW-1:0]  out_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic signed [DW-1:0] a, b, c, d;
    logic signed [DW-1:0] exp_raw, exp_relu;
  } win_t;

  win_t tbl[8];

  logic [OL*DW-1:0] got_data[$];
  logic             got_last[$];
  int               done_cnt = 0;

  maxpool_2x2_stream #(
    .SYSTOLIC_SIZE(SS),
    .DATA_WIDTH   (DW),
    .LINE_TILES   (LT),
    .CONV_ROWS    (CR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row_last(out_row_last),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Transfers and done pulses are observed on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_row_last);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] expected(input int w);
`ifdef MAXPOOL_RELU_EN
    return tbl[w].exp_relu;
`else
    return tbl[w].exp_raw;
`endif
  endfunction

  // Row 2 carries large junk values that must never reach the output.
  function automatic logic [SS*DW-1:0] beat(input int row, input int tile, input int base);
    logic [SS*DW-1:0] v;
    v = '0;
    for (int j = 0; j < OL; j++) begin
      if (row == 0) begin
        v[(2*j)*DW +: DW]   = tbl[base + 2*tile + j].a;
        v[(2*j+1)*DW +: DW] = tbl[base + 2*tile + j].b;
      end else if (row == 1) begin
        v[(2*j)*DW +: DW]   = tbl[base + 2*tile + j].c;
        v[(2*j+1)*DW +: DW] = tbl[base + 2*tile + j].d;
      end else begin
        v[(2*j)*DW +: DW]   = 16'sh7fff;
        v[(2*j+1)*DW +: DW] = 16'sh7ffe;
      end
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic [SS*DW-1:0] d, input string name);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check(name, ok, 1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic checkOutput(input int base);
    for (int i = 0; i < 50 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("beat_count", got_data.size(), 2);
    check("done_count", done_cnt, 1);
    check("idle_in_ready", in_ready, 0);
    if (got_data.size() >= 2) begin
      for (int t = 0; t < 2; t++) begin
        for (int j = 0; j < OL; j++)
          check($sformatf("lane_b%0d_t%0d_j%0d", base, t, j),
                $signed(got_data[t][j*DW +: DW]), expected(base + 2*t + j));
        check($sformatf("row_last_b%0d_t%0d", base, t), got_last[t], (t == 1) ? 1 : 0);
      end
    end
  endtask

  task automatic run_plane(input int base);
    got_data.delete();
    got_last.delete();
    done_cnt = 0;
    pulse_start();
    for (int r = 0; r < CR; r++)
      for (int t = 0; t < LT; t++)
        applyStimulus(beat(r, t, base), $sformatf("accept_r%0d_t%0d", r, t));
    checkOutput(base);
  endtask

  initial begin
    tbl[0] = '{16'sd0,      16'sd1,      16'sd100, 16'sd101,  16'sd101,   16'sd101};
    tbl[1] = '{16'sd2,      16'sd3,      16'sd102, 16'sd103,  16'sd103,   16'sd103};
    tbl[2] = '{-16'sd5,     -16'sd3,     -16'sd7,  -16'sd9,   -16'sd3,    16'sd0};
    tbl[3] = '{-16'sd32768, -16'sd1,     -16'sd2,  -16'sd100, -16'sd1,    16'sd0};
    tbl[4] = '{16'sd32767,  -16'sd32768, 16'sd0,   16'sd5,    16'sd32767, 16'sd32767};
    tbl[5] = '{16'sd7,      16'sd7,      16'sd7,   16'sd7,    16'sd7,     16'sd7};
    tbl[6] = '{-16'sd4,     16'sd10,     16'sd3,   -16'sd20,  16'sd10,    16'sd10};
    tbl[7] = '{16'sd50,     -16'sd50,    16'sd60,  -16'sd60,  16'sd60,    16'sd60};

    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_done", done, 0);

    // Valid beats without start must be ignored in IDLE.
    in_valid = 1'b1;
    in_data  = beat(0, 0, 0);
    begin
      int ready_seen;
      ready_seen = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (in_ready) ready_seen++;
      end
      check("idle_no_ready", ready_seen, 0);
    end
    in_valid = 1'b0;
    check("idle_no_output", got_data.size(), 0);

    run_plane(0);

    // Stall the first pooled beat for five cycles while the producer keeps pushing.
    out_ready = 1'b0;
    fork
      run_plane(4);
      begin
        logic [OL*DW-1:0] snap;
        int seen;
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
          @(negedge clk);
          if (out_valid) seen = 1;
        end
        check("stall_valid_seen", seen, 1);
        snap = out_data;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_data_stable", out_data, snap);
          check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join

    // Reset with a pooled beat pending must drop it and suppress done.
    out_ready = 1'b0;
    got_data.delete();
    got_last.delete();
    done_cnt = 0;
    pulse_start();
    applyStimulus(beat(0, 0, 0), "mid_r0_t0");
    applyStimulus(beat(0, 1, 0), "mid_r0_t1");
    applyStimulus(beat(1, 0, 0), "mid_r1_t0");
    @(negedge clk);
    check("mid_out_valid_before", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_out_valid_after", out_valid, 0);
    check("mid_in_ready_after", in_ready, 0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_no_done", done_cnt, 0);
    check("mid_no_output", got_data.size(), 0);

    run_plane(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
